// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered one-hot and binary grant outputs and a valid/ready grant handshake.
// Optional grant lock (holds the rotation pointer on handshake) is built when RR_GRANT_LOCK_EN is defined.
module rr_grant_encoder #(
  parameter int IN_W  = 8,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  req,
  input  logic             gnt_ready,
`ifdef RR_GRANT_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt_valid,
  output logic [IN_W-1:0]  gnt_oh,
  output logic [OUT_W-1:0] gnt_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [OUT_W-1:0] ptr, ptr_n;
  logic             valid_n;
  logic [IN_W-1:0]  oh_n;
  logic [OUT_W-1:0] idx_n;

  logic             handshake;
  logic             lock_eff;
  logic             holder_active;
  logic [OUT_W-1:0] adv_ptr;
  logic [OUT_W-1:0] search_ptr;
  logic [IN_W-1:0]  upper_req;
  logic [OUT_W-1:0] win_idx;
  logic [IN_W-1:0]  win_oh;
  logic             any_req;

  function automatic logic [OUT_W-1:0] lowest_set(input logic [IN_W-1:0] v);
    lowest_set = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = OUT_W'(i);
    end
  endfunction

`ifdef RR_GRANT_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  assign handshake     = (state == GRANT) && gnt_ready;
  assign any_req       = |req;
  assign holder_active = |(req & gnt_oh);

  // Wrap explicitly at IN_W-1 so non-power-of-two widths never point past the last requester.
  assign adv_ptr = (gnt_idx == OUT_W'(IN_W - 1)) ? '0 : gnt_idx + OUT_W'(1);

  always_comb begin
    search_ptr = ptr;
    if (handshake) begin
      if (!lock_eff)          search_ptr = adv_ptr;
      else if (holder_active) search_ptr = gnt_idx;
    end
  end

  // Bits at or above the pointer win first; otherwise wrap to the lowest request overall.
  assign upper_req = req & ({IN_W{1'b1}} << search_ptr);
  assign win_idx   = (|upper_req) ? lowest_set(upper_req) : lowest_set(req);
  assign win_oh    = {{(IN_W-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = gnt_valid;
    oh_n    = gnt_oh;
    idx_n   = gnt_idx;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = GRANT;
          valid_n = 1'b1;
          oh_n    = win_oh;
          idx_n   = win_idx;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (!lock_eff) ptr_n = adv_ptr;
          if (any_req) begin
            oh_n  = win_oh;
            idx_n = win_idx;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            oh_n    = '0;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        oh_n    = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_valid <= 1'b0;
      gnt_oh    <= '0;
      gnt_idx   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_valid <= valid_n;
      gnt_oh    <= oh_n;
      gnt_idx   <= idx_n;
    end
  end

  // Structural invariants of the registered grant.
  a_onehot_when_valid : assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> $onehot(gnt_oh));
  a_zero_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !gnt_valid |-> (gnt_oh == '0) && (gnt_idx == '0));
  a_hold_under_backpressure : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_valid && !gnt_ready) |=> (gnt_valid && $stable(gnt_oh) && $stable(gnt_idx)));

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: vector table plus directed reset, fairness, wrap and lock sequences.
// Expected grants are queued at drive time and popped when the registered outputs are sampled.
module tb_rr_grant_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic       rdy8;
  logic       v8;
  logic [7:0] oh8;
  logic [2:0] idx8;
  logic [4:0] req5;
  logic       rdy5;
  logic       v5;
  logic [4:0] oh5;
  logic [2:0] idx5;
`ifdef RR_GRANT_LOCK_EN
  logic       lock8;
`endif

  always #5 clk = ~clk;

  rr_grant_encoder #(.IN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt_ready(rdy8),
`ifdef RR_GRANT_LOCK_EN
    .lock(lock8),
`endif
    .gnt_valid(v8), .gnt_oh(oh8), .gnt_idx(idx8)
  );

  rr_grant_encoder #(.IN_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .gnt_ready(rdy5),
`ifdef RR_GRANT_LOCK_EN
    .lock(1'b0),
`endif
    .gnt_valid(v5), .gnt_oh(oh5), .gnt_idx(idx5)
  );

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       exp_v;
    int         exp_idx;
  } vec_t;

  typedef struct {
    bit    sel5;
    logic  lk;
    logic  exp_v;
    int    exp_idx;
    string name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[19];
  int   passed = 0;
  int   total  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [7:0] eoh;
    if (sb.size() == 0) begin
      total++;
      $display("[TB] FAIL scoreboard_underflow: got 0 entries, expected 1");
      return;
    end
    e   = sb.pop_front();
    eoh = e.exp_v ? (8'h01 << e.exp_idx) : 8'h00;
    if (e.sel5) begin
      check({e.name, "_valid"}, 32'(v5), 32'(e.exp_v));
      check({e.name, "_idx"}, 32'(idx5), 32'(e.exp_idx));
      check({e.name, "_oh"}, 32'(oh5), 32'(eoh));
    end else begin
      check({e.name, "_valid"}, 32'(v8), 32'(e.exp_v));
      check({e.name, "_idx"}, 32'(idx8), 32'(e.exp_idx));
      check({e.name, "_oh"}, 32'(oh8), 32'(eoh));
    end
  endtask

  // Drive one cycle of inputs, queue what the next edge must produce, then compare.
  task automatic applyStimulus(input bit sel5, input logic [7:0] r, input logic rdy,
                               input logic lk, input logic ev, input int eidx, input string name);
    exp_t e;
    @(negedge clk);
    if (sel5) begin
      req5 = r[4:0];
      rdy5 = rdy;
    end else begin
      req8 = r;
      rdy8 = rdy;
    end
`ifdef RR_GRANT_LOCK_EN
    lock8 = lk;
`endif
    e.sel5    = sel5;
    e.lk      = lk;
    e.exp_v   = ev;
    e.exp_idx = eidx;
    e.name    = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    req8  = '0;
    rdy8  = 1'b0;
    req5  = '0;
    rdy5  = 1'b0;
`ifdef RR_GRANT_LOCK_EN
    lock8 = 1'b0;
`endif

    // {req, ready, expected valid, expected idx}; state carries from row to row.
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 0};
    tbl[1]  = '{8'h08, 1'b0, 1'b1, 3};
    tbl[2]  = '{8'h08, 1'b0, 1'b1, 3};
    tbl[3]  = '{8'h00, 1'b1, 1'b0, 0};
    tbl[4]  = '{8'hFF, 1'b1, 1'b1, 4};
    tbl[5]  = '{8'hFF, 1'b1, 1'b1, 5};
    tbl[6]  = '{8'hFF, 1'b1, 1'b1, 6};
    tbl[7]  = '{8'hFF, 1'b1, 1'b1, 7};
    tbl[8]  = '{8'hFF, 1'b1, 1'b1, 0};
    tbl[9]  = '{8'h04, 1'b1, 1'b1, 2};
    tbl[10] = '{8'hF0, 1'b0, 1'b1, 2};
    tbl[11] = '{8'h01, 1'b0, 1'b1, 2};
    tbl[12] = '{8'hFF, 1'b0, 1'b1, 2};
    tbl[13] = '{8'hFF, 1'b1, 1'b1, 3};
    tbl[14] = '{8'h03, 1'b1, 1'b1, 0};
    tbl[15] = '{8'h02, 1'b0, 1'b1, 0};
    tbl[16] = '{8'h02, 1'b1, 1'b1, 1};
    tbl[17] = '{8'h00, 1'b1, 1'b0, 0};
    tbl[18] = '{8'h01, 1'b0, 1'b1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid8", 32'(v8), 32'd0);
    check("reset_oh8", 32'(oh8), 32'd0);
    check("reset_idx8", 32'(idx8), 32'd0);
    check("reset_valid5", 32'(v5), 32'd0);
    check("reset_oh5", 32'(oh5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++)
      applyStimulus(1'b0, tbl[i].req, tbl[i].rdy, 1'b0, tbl[i].exp_v, tbl[i].exp_idx,
                    $sformatf("vec%0d", i));

    // Asynchronous reset while a grant is held must clear outputs without a clock edge.
    @(negedge clk);
    req8 = '0;
    rdy8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(v8), 32'd0);
    check("async_reset_oh", 32'(oh8), 32'd0);
    check("async_reset_idx", 32'(idx8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, k % 8, $sformatf("fair%0d", k));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, "fair_drain");

    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 0, "w5_a");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 4, "w5_b");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 0, "w5_c");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 4, "w5_d");
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0, "w5_idle");
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0, "w5_idle2");

`ifdef RR_GRANT_LOCK_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 1, "lock_first");
    applyStimulus(1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 1, "lock_hold1");
    applyStimulus(1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 1, "lock_hold2");
    applyStimulus(1'b0, 8'h06, 1'b1, 1'b0, 1'b1, 2, "lock_release");
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
